// File: rtl/ewrapper_pkg.sv
// ewrapper_pkg: constants and types shared by the eLink wrapper receive path.
//   EW_NUM_CH       data + frame channels carried per link
//   EW_BITS_PER_CH  bits reassembled per channel per word
//   EW_PHASES       fast-clock cycles (DDR pairs) per word
//   EW_FRAME_CH     channel index carrying the frame signal
//   rx_align_state_e  byte-aligner states (HUNT, LOCKED)
package ewrapper_pkg;

    localparam int EW_NUM_CH      = 9;
    localparam int EW_BITS_PER_CH = 8;
    localparam int EW_PHASES      = 4;
    localparam int EW_FRAME_CH    = 8;
    localparam int EW_WORD_W      = EW_NUM_CH * EW_BITS_PER_CH;
    localparam int EW_PH_W        = $clog2(EW_PHASES);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } rx_align_state_e;

endpackage

// File: rtl/ewrapper_rx_align.sv
// ewrapper_rx_align: frame-edge detector, byte-phase counter, alignment FSM
// and saturating alignment-error counter.
// Ports:
//   clk, rst_n   fast link clock, async active-low reset
//   frame_even   frame-channel rising-edge sample (already conditioned)
//   frame_odd    frame-channel falling-edge sample, same-cycle pair
//   phase        phase of the pair presented this cycle (combinational)
//   capture      this cycle's pair belongs to an aligned word (combinational)
//   locked       registered: aligner is in LOCKED
//   err          registered one-cycle pulse per misaligned frame edge
//   err_cnt      saturating count of err pulses
module ewrapper_rx_align
    import ewrapper_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_even,
    input  logic               frame_odd,
    output logic [EW_PH_W-1:0] phase,
    output logic               capture,
    output logic               locked,
    output logic               err,
    output logic [7:0]         err_cnt
);

    rx_align_state_e    state_q, state_d;
    logic [EW_PH_W-1:0] phase_q;
    logic               prev_odd_q;
    logic               err_q;
    logic               err_now;
    logic               even_edge, odd_edge;

    // A rising frame that starts on the even sample is a byte boundary; one
    // that starts on the odd sample is half a bit-pair off and unusable.
    assign even_edge = !prev_odd_q && frame_even && frame_odd;
    assign odd_edge  = !frame_even && frame_odd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (even_edge) state_d = LOCKED;
            LOCKED:  if (odd_edge)  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        err_now = 1'b0;
        capture = 1'b0;
        phase   = phase_q;
        case (state_q)
            HUNT: begin
                if (even_edge) begin
                    capture = 1'b1;
                    phase   = '0;
                end
                if (odd_edge) err_now = 1'b1;
            end
            LOCKED: begin
                if (odd_edge) begin
                    err_now = 1'b1;
                end else begin
                    capture = 1'b1;
                    // Edge away from phase 0 restarts the word here; the
                    // partial word never reaches phase 3 so it is dropped.
                    if (even_edge) begin
                        phase = '0;
                        if (phase_q != '0) err_now = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            prev_odd_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            prev_odd_q <= frame_odd;
            phase_q    <= capture ? phase + 1'b1 : '0;
            err_q      <= err_now;
            if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign locked = (state_q == LOCKED);
    assign err    = err_q;

endmodule

// File: rtl/ewrapper_io_rx_deser.sv
// ewrapper_io_rx_deser: eLink receive deserializer and byte aligner.
// Collects four DDR sample pairs per channel, aligned to the frame channel,
// into one 72-bit word (9 channels x 8 bits, first wire bit = byte MSB).
// Build option: define ELINK_INVERT_EN to invert all even/odd samples
// (frame included) at the input, for the E64 target.
// Ports:
//   CLK_IN             fast link clock (IDDR clock)
//   RESET_N            async active-low reset
//   DATA_EVEN_IN[8:0]  rising-edge samples, channel 8 is frame
//   DATA_ODD_IN[8:0]   falling-edge samples, same-cycle pair
//   DATA_IN_TO_DEVICE  reassembled word, held between strobes
//   DATA_VALID         one-cycle strobe per new word
//   ALIGN_LOCKED       aligner locked to frame
//   ALIGN_ERR          one-cycle pulse per misaligned frame edge
//   ERR_CNT            saturating ALIGN_ERR count
module ewrapper_io_rx_deser
    import ewrapper_pkg::*;
(
    input  logic                 CLK_IN,
    input  logic                 RESET_N,
    input  logic [EW_NUM_CH-1:0] DATA_EVEN_IN,
    input  logic [EW_NUM_CH-1:0] DATA_ODD_IN,
    output logic [EW_WORD_W-1:0] DATA_IN_TO_DEVICE,
    output logic                 DATA_VALID,
    output logic                 ALIGN_LOCKED,
    output logic                 ALIGN_ERR,
    output logic [7:0]           ERR_CNT
);

    logic [EW_NUM_CH-1:0]                  even_s, odd_s;
    logic [EW_PHASES-2:0][EW_NUM_CH-1:0]   stage_even, stage_odd;
    logic [EW_PHASES-1:0][EW_NUM_CH-1:0]   ph_even, ph_odd;
    logic [EW_WORD_W-1:0]                  word_d, data_q;
    logic [EW_PH_W-1:0]                    phase;
    logic                                  capture, valid_q, last_phase;

`ifdef ELINK_INVERT_EN
    assign even_s = ~DATA_EVEN_IN;
    assign odd_s  = ~DATA_ODD_IN;
`else
    assign even_s = DATA_EVEN_IN;
    assign odd_s  = DATA_ODD_IN;
`endif

    ewrapper_rx_align u_align (
        .clk        (CLK_IN),
        .rst_n      (RESET_N),
        .frame_even (even_s[EW_FRAME_CH]),
        .frame_odd  (odd_s[EW_FRAME_CH]),
        .phase      (phase),
        .capture    (capture),
        .locked     (ALIGN_LOCKED),
        .err        (ALIGN_ERR),
        .err_cnt    (ERR_CNT)
    );

    assign last_phase = capture && (phase == EW_PH_W'(EW_PHASES - 1));

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            stage_even <= '0;
            stage_odd  <= '0;
        end else if (capture) begin
            for (int k = 0; k < EW_PHASES - 1; k++) begin
                if (phase == EW_PH_W'(k)) begin
                    stage_even[k] <= even_s;
                    stage_odd[k]  <= odd_s;
                end
            end
        end
    end

    // Phase 3 comes straight from the pins so the word lands on the same edge.
    assign ph_even = {even_s, stage_even};
    assign ph_odd  = {odd_s,  stage_odd};

    for (genvar ch = 0; ch < EW_NUM_CH; ch++) begin : g_ch
        for (genvar k = 0; k < EW_PHASES; k++) begin : g_ph
            assign word_d[EW_BITS_PER_CH*ch + EW_BITS_PER_CH - 1 - 2*k] = ph_even[k][ch];
            assign word_d[EW_BITS_PER_CH*ch + EW_BITS_PER_CH - 2 - 2*k] = ph_odd[k][ch];
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= last_phase;
            if (last_phase) data_q <= word_d;
        end
    end

    assign DATA_IN_TO_DEVICE = data_q;
    assign DATA_VALID        = valid_q;

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
// Testbench for ewrapper_io_rx_deser. Words are serialized MSB-first per
// channel; a scoreboard holds the cycle and value each word must appear at,
// and the cycles at which ALIGN_ERR must pulse.
module tb_ewrapper_io_rx_deser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  even_in, odd_in;
    logic [71:0] data;
    logic        valid, locked, err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int lock_rise_cyc = -1;
    logic locked_prev = 1'b0;

    typedef struct {
        int          cyc;
        logic [71:0] w;
    } exp_t;
    exp_t exp_q[$];
    int   err_exp_q[$];

    logic [7:0] fr_tab [6] = '{8'hF0, 8'hFF, 8'hC0, 8'hE0, 8'hF8, 8'hFC};

    ewrapper_io_rx_deser dut (
        .CLK_IN            (clk),
        .RESET_N           (rst_n),
        .DATA_EVEN_IN      (even_in),
        .DATA_ODD_IN       (odd_in),
        .DATA_IN_TO_DEVICE (data),
        .DATA_VALID        (valid),
        .ALIGN_LOCKED      (locked),
        .ALIGN_ERR         (err),
        .ERR_CNT           (err_cnt)
    );

    // Wire levels as the sender means them; the E64 build sees them inverted.
    task automatic apply(input logic [8:0] e, input logic [8:0] o);
`ifdef ELINK_INVERT_EN
        even_in = ~e;
        odd_in  = ~o;
`else
        even_in = e;
        odd_in  = o;
`endif
    endtask

    task automatic step(input logic [8:0] e, input logic [8:0] o);
        apply(e, o);
        @(posedge clk);
        #1;
    endtask

    // Serialize the first nph bit-pairs of every channel byte, MSB first.
    task automatic send_phases(input logic [71:0] w, input int nph);
        logic [8:0] e, o;
        logic [7:0] b;
        for (int k = 0; k < nph; k++) begin
            for (int c = 0; c < 9; c++) begin
                b    = w[8*c +: 8];
                b    = b << (2*k);
                e[c] = b[7];
                o[c] = b[6];
            end
            step(e, o);
        end
    endtask

    task automatic send_word(input logic [71:0] w, input bit expect_out);
        exp_t x;
        if (expect_out) begin
            x.cyc = cyc + 4;
            x.w   = w;
            exp_q.push_back(x);
        end
        send_phases(w, 4);
    endtask

    function automatic logic [71:0] rand_word(input logic [7:0] fb);
        logic [63:0] d;
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        return {fb, d};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        apply('0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        exp_t x;
        int   ec;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL valid_unexpected: cycle %0d data %h, required no strobe", cyc, data);
                end else begin
                    x = exp_q.pop_front();
                    if (cyc != x.cyc || data !== x.w) begin
                        n_fail++;
                        $display("FAIL valid_word: cycle %0d data %h, required cycle %0d data %h",
                                 cyc, data, x.cyc, x.w);
                    end
                end
            end
            if (err === 1'b1) begin
                n_checks++;
                if (err_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: ALIGN_ERR at cycle %0d, required none", cyc);
                end else begin
                    ec = err_exp_q.pop_front();
                    if (cyc != ec) begin
                        n_fail++;
                        $display("FAIL err_cycle: ALIGN_ERR at cycle %0d, required cycle %0d", cyc, ec);
                    end
                end
            end
            if (locked === 1'b1 && locked_prev !== 1'b1) lock_rise_cyc = cyc;
            locked_prev = locked;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(9'($urandom()), 9'($urandom()));
        n_checks += 5;
        if (data !== 72'h0)   begin n_fail++; $display("FAIL reset_data: got %h, required 0", data); end
        if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
        if (locked !== 1'b0)  begin n_fail++; $display("FAIL reset_locked: got %b, required 0", locked); end
        if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_errcnt: got %h, required 0", err_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_lock();
        int t_rst, t0;
        logic [71:0] w;
        do_reset();
        t_rst = cyc;
        while (cyc < t_rst + 10) step('0, '0);
        t0 = cyc;
        // Data channels carry A5; the frame channel carries its own F0 pattern.
        w = {8'hF0, {8{8'hA5}}};
        send_word(w, 1'b1);
        @(negedge clk); #1;
        n_checks += 3;
        if (lock_rise_cyc != t0 + 1) begin n_fail++; $display("FAIL lock_cycle: rose at %0d, required %0d", lock_rise_cyc, t0 + 1); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL lock_word_missing: %0d words pending, required 0", exp_q.size()); end
        if (locked !== 1'b1)   begin n_fail++; $display("FAIL lock_level: got %b, required 1", locked); end
        step('0, '0);
        step('0, '0);
        n_checks += 2;
        if (data !== w)      begin n_fail++; $display("FAIL data_hold: got %h, required %h", data, w); end
        if (valid !== 1'b0)  begin n_fail++; $display("FAIL valid_between: got %b, required 0", valid); end
    endtask

    task automatic test_frame_high();
        int v0;
        do_reset();
        step('0, '0);
        v0 = n_valid;
        for (int i = 0; i < 5; i++) send_word(rand_word(8'hFF), 1'b1);
        @(negedge clk); #1;
        n_checks += 3;
        if (n_valid - v0 != 5) begin n_fail++; $display("FAIL frame_high_count: %0d strobes, required 5", n_valid - v0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_high_pending: %0d words, required 0", exp_q.size()); end
        if (err_cnt !== 8'h0)  begin n_fail++; $display("FAIL frame_high_errcnt: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_random_stream();
        int v0;
        do_reset();
        step('0, '0);
        v0 = n_valid;
        for (int i = 0; i < 24; i++) send_word(rand_word(fr_tab[$urandom_range(0, 5)]), 1'b1);
        @(negedge clk); #1;
        n_checks += 3;
        if (n_valid - v0 != 24) begin n_fail++; $display("FAIL random_count: %0d strobes, required 24", n_valid - v0); end
        if (exp_q.size() != 0)  begin n_fail++; $display("FAIL random_pending: %0d words, required 0", exp_q.size()); end
        if (err_cnt !== 8'h0)   begin n_fail++; $display("FAIL random_errcnt: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_misaligned();
        do_reset();
        step('0, '0);
        send_word(rand_word(8'hF0), 1'b1);
        send_phases(rand_word(8'hC0), 2);
        err_exp_q.push_back(cyc + 1);
        send_word(rand_word(8'hF0), 1'b1);
        @(negedge clk); #1;
        n_checks += 4;
        if (exp_q.size() != 0)     begin n_fail++; $display("FAIL misalign_pending: %0d words, required 0", exp_q.size()); end
        if (err_exp_q.size() != 0) begin n_fail++; $display("FAIL misalign_err_missing: %0d pulses, required 0", err_exp_q.size()); end
        if (err_cnt !== 8'd1)      begin n_fail++; $display("FAIL misalign_errcnt: got %0d, required 1", err_cnt); end
        if (locked !== 1'b1)       begin n_fail++; $display("FAIL misalign_locked: got %b, required 1", locked); end
    endtask

    task automatic test_odd_edge();
        do_reset();
        step('0, '0);
        send_word(rand_word(8'hF0), 1'b1);
        err_exp_q.push_back(cyc + 1);
        step({1'b0, 8'($urandom())}, {1'b1, 8'($urandom())});
        for (int i = 0; i < 5; i++) step({1'b0, 8'($urandom())}, {1'b0, 8'($urandom())});
        @(negedge clk); #1;
        n_checks += 2;
        if (locked !== 1'b0)   begin n_fail++; $display("FAIL odd_edge_unlock: got %b, required 0", locked); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL odd_edge_pending: %0d words, required 0", exp_q.size()); end
        send_word(rand_word(8'hF0), 1'b1);
        @(negedge clk); #1;
        n_checks += 4;
        if (exp_q.size() != 0)     begin n_fail++; $display("FAIL relock_pending: %0d words, required 0", exp_q.size()); end
        if (err_exp_q.size() != 0) begin n_fail++; $display("FAIL odd_edge_err_missing: %0d pulses, required 0", err_exp_q.size()); end
        if (locked !== 1'b1)       begin n_fail++; $display("FAIL relock_level: got %b, required 1", locked); end
        if (err_cnt !== 8'd1)      begin n_fail++; $display("FAIL odd_edge_errcnt: got %0d, required 1", err_cnt); end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 301; i++) begin
            err_exp_q.push_back(cyc + 1);
            step({1'b0, 8'($urandom())}, {1'b1, 8'($urandom())});
            if (i == 99) begin
                n_checks++;
                if (err_cnt !== 8'd100) begin n_fail++; $display("FAIL errcnt_mid: got %0d, required 100", err_cnt); end
            end
            if (i == 254) begin
                n_checks++;
                if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL errcnt_reach: got %0d, required 255", err_cnt); end
            end
        end
        @(negedge clk); #1;
        n_checks += 3;
        if (err_cnt !== 8'hFF)     begin n_fail++; $display("FAIL errcnt_sat: got %0d, required 255", err_cnt); end
        if (locked !== 1'b0)       begin n_fail++; $display("FAIL sat_locked: got %b, required 0", locked); end
        if (err_exp_q.size() != 0) begin n_fail++; $display("FAIL sat_err_missing: %0d pulses, required 0", err_exp_q.size()); end
    endtask

    task automatic test_reset_midword();
        logic [71:0] w1;
        do_reset();
        step('0, '0);
        w1 = rand_word(8'hF0);
        send_word(w1, 1'b1);
        send_phases(rand_word(8'hF0), 2);
        n_checks++;
        if (data !== w1) begin n_fail++; $display("FAIL pre_reset_data: got %h, required %h", data, w1); end
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (data !== 72'h0)   begin n_fail++; $display("FAIL async_reset_data: got %h, required 0", data); end
        if (valid !== 1'b0)   begin n_fail++; $display("FAIL async_reset_valid: got %b, required 0", valid); end
        if (locked !== 1'b0)  begin n_fail++; $display("FAIL async_reset_locked: got %b, required 0", locked); end
        if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL async_reset_errcnt: got %0d, required 0", err_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(rand_word(8'h00), 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL no_edge_locked: got %b, required 0", locked); end
        send_word(rand_word(8'hF0), 1'b1);
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL post_reset_pending: %0d words, required 0", exp_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        apply('0, '0);
        test_reset();
        test_first_lock();
        test_frame_high();
        test_random_stream();
        test_misaligned();
        test_odd_edge();
        test_err_saturate();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
